// File: rtl/eth_udp_pkg.sv
// Shared types and constants for the GMII UDP/IPv4 receive path.
// Optional build macro: UDP_RX_CRC_CHECK_EN (enables FCS checking).
package eth_udp_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        ETH_HDR,
        IP_HDR,
        UDP_HDR,
        PAYLOAD,
        TRAILER,
        DROP
    } rx_state_t;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IP_PROTO_UDP  = 8'd17;
    localparam logic [7:0]  IP_VER_IHL    = 8'h45;

    localparam int ETH_HDR_LEN = 14;
    localparam int IP_HDR_LEN  = 20;
    localparam int UDP_HDR_LEN = 8;

    // Good-frame residue in MSB-first form.
    localparam logic [31:0] CRC_RESIDUE   = 32'hC704DD7B;
    // 0x04C11DB7 bit-reversed for the LSB-first shifter.
    localparam logic [31:0] CRC_POLY_REFL = 32'hEDB88320;

    function automatic logic [31:0] bitrev32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/eth_udp_rx_gmii_crc32_d8.sv
// Byte-wide reflected CRC-32 engine (init all-ones).
// Built into eth_udp_rx_gmii only with UDP_RX_CRC_CHECK_EN.
module crc32_d8
    import eth_udp_pkg::*;
(
    input  logic        clk_125m,
    input  logic        udp_gmii_rst_n,
    input  logic        init,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [31:0] crc
);

    logic [31:0] r;
    logic [31:0] nx;

    // Fold one byte in, LSB first.
    always_comb begin
        nx = r;
        for (int i = 0; i < 8; i++) begin
            if (nx[0] ^ data[i]) begin
                nx = (nx >> 1) ^ CRC_POLY_REFL;
            end else begin
                nx = nx >> 1;
            end
        end
    end

    // Running remainder, re-seeded at each SFD.
    always_ff @(posedge clk_125m or negedge udp_gmii_rst_n) begin
        if (!udp_gmii_rst_n) begin
            r <= '1;
        end else if (init) begin
            r <= '1;
        end else if (en) begin
            r <= nx;
        end
    end

    // Present the remainder MSB-first so it matches CRC_RESIDUE.
    assign crc = bitrev32(r);

endmodule

// File: rtl/eth_udp_rx_gmii.sv
// GMII UDP/IPv4 receiver: strip headers, filter, stream payload.
// Optional build macro: UDP_RX_CRC_CHECK_EN (FCS check at frame end).
module eth_udp_rx_gmii
    import eth_udp_pkg::*;
#(
    parameter int MAX_PAYLOAD = 1472
) (
    input  logic        clk_125m,
    input  logic        udp_gmii_rst_n,
    input  logic        gmii_rx_dv,
    input  logic [7:0]  gmii_rxd,
    input  logic [47:0] local_mac,
    input  logic [31:0] local_ip,
    input  logic [15:0] local_port,
    output logic        payload_valid_o,
    output logic [7:0]  payload_dat_o,
    output logic        payload_last_o,
    output logic        rx_done,
    output logic        rx_err,
    output logic [47:0] src_mac,
    output logic [31:0] src_ip,
    output logic [15:0] src_port,
    output logic [15:0] data_len
);

    localparam logic [15:0] ETH_LAST = 16'(ETH_HDR_LEN - 1);
    localparam logic [15:0] IP_LAST  = 16'(IP_HDR_LEN - 1);
    localparam logic [15:0] UDP_LAST = 16'(UDP_HDR_LEN - 1);
    localparam logic [15:0] LEN_MIN  = 16'(UDP_HDR_LEN);
    localparam logic [15:0] LEN_MAX  = 16'(MAX_PAYLOAD + UDP_HDR_LEN);

    rx_state_t   st;
    rx_state_t   nxt;
    logic [15:0] cnt;
    logic        uc_ok;
    logic        bc_ok;
    logic        uc_now;
    logic        bc_now;
    logic [2:0]  mac_idx;
    logic [7:0]  mac_byte;
    logic [7:0]  ip_byte;
    logic [7:0]  port_byte;
    logic [15:0] len_now;
    logic [47:0] sh_mac;
    logic [31:0] sh_ip;
    logic [15:0] sh_port;
    logic [15:0] sh_len;
    logic        eth_bad;
    logic        ip_bad;
    logic        udp_bad;
    logic        crc_ok;

    assign mac_idx   = 3'd5 - cnt[2:0];
    assign mac_byte  = 8'(local_mac >> {mac_idx, 3'b000});
    assign ip_byte   = 8'(local_ip >> {~cnt[1:0], 3'b000});
    assign port_byte = cnt[0] ? local_port[7:0] : local_port[15:8];
    assign len_now   = {sh_len[7:0], gmii_rxd};

    // Unicast and broadcast matches are tracked separately so a
    // mix of ff bytes and station bytes is rejected.
    assign uc_now = (cnt == 16'd0 || uc_ok) && gmii_rxd == mac_byte;
    assign bc_now = (cnt == 16'd0 || bc_ok) && gmii_rxd == 8'hff;

    assign eth_bad =
        (cnt == 16'd5 && !(uc_now || bc_now)) ||
        (cnt == 16'd12 && gmii_rxd != ETH_TYPE_IPV4[15:8]) ||
        (cnt == 16'd13 && gmii_rxd != ETH_TYPE_IPV4[7:0]);

    assign ip_bad =
        (cnt == 16'd0 && gmii_rxd != IP_VER_IHL) ||
        (cnt == 16'd9 && gmii_rxd != IP_PROTO_UDP) ||
        (cnt >= 16'd16 && gmii_rxd != ip_byte);

    assign udp_bad =
        ((cnt == 16'd2 || cnt == 16'd3) && gmii_rxd != port_byte) ||
        (cnt == 16'd5 && (len_now < LEN_MIN || len_now > LEN_MAX));

`ifdef UDP_RX_CRC_CHECK_EN
    logic        crc_init;
    logic        crc_en;
    logic [31:0] crc_val;

    assign crc_init = st == PREAMBLE && gmii_rx_dv &&
                      gmii_rxd == SFD_BYTE;
    assign crc_en   = gmii_rx_dv &&
                      st inside {ETH_HDR, IP_HDR, UDP_HDR,
                                 PAYLOAD, TRAILER};

    crc32_d8 u_crc (
        .clk_125m       (clk_125m),
        .udp_gmii_rst_n (udp_gmii_rst_n),
        .init           (crc_init),
        .en             (crc_en),
        .data           (gmii_rxd),
        .crc            (crc_val)
    );

    assign crc_ok = crc_val == CRC_RESIDUE;
`else
    assign crc_ok = 1'b1;
`endif

    // State register.
    always_ff @(posedge clk_125m or negedge udp_gmii_rst_n) begin
        if (!udp_gmii_rst_n) begin
            st <= IDLE;
        end else begin
            st <= nxt;
        end
    end

    // Next-state decode; a dv drop in any state ends the frame.
    always_comb begin
        nxt = st;
        unique case (st)
            IDLE: begin
                if (gmii_rx_dv) begin
                    nxt = (gmii_rxd == PREAMBLE_BYTE) ? PREAMBLE : DROP;
                end
            end
            PREAMBLE: begin
                if (!gmii_rx_dv)                 nxt = IDLE;
                else if (gmii_rxd == SFD_BYTE)   nxt = ETH_HDR;
                else if (gmii_rxd != PREAMBLE_BYTE) nxt = DROP;
            end
            ETH_HDR: begin
                if (!gmii_rx_dv)          nxt = IDLE;
                else if (eth_bad)         nxt = DROP;
                else if (cnt == ETH_LAST) nxt = IP_HDR;
            end
            IP_HDR: begin
                if (!gmii_rx_dv)         nxt = IDLE;
                else if (ip_bad)         nxt = DROP;
                else if (cnt == IP_LAST) nxt = UDP_HDR;
            end
            UDP_HDR: begin
                if (!gmii_rx_dv)      nxt = IDLE;
                else if (udp_bad)     nxt = DROP;
                else if (cnt == UDP_LAST) begin
                    nxt = (sh_len == LEN_MIN) ? TRAILER : PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (!gmii_rx_dv) nxt = IDLE;
                else if (cnt == data_len - 16'd1) nxt = TRAILER;
            end
            TRAILER: begin
                if (!gmii_rx_dv) nxt = IDLE;
            end
            DROP: begin
                if (!gmii_rx_dv) nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    // Byte counter, header shadows, metadata commit and outputs.
    always_ff @(posedge clk_125m or negedge udp_gmii_rst_n) begin
        if (!udp_gmii_rst_n) begin
            cnt             <= '0;
            uc_ok           <= 1'b0;
            bc_ok           <= 1'b0;
            sh_mac          <= '0;
            sh_ip           <= '0;
            sh_port         <= '0;
            sh_len          <= '0;
            payload_valid_o <= 1'b0;
            payload_dat_o   <= '0;
            payload_last_o  <= 1'b0;
            rx_done         <= 1'b0;
            rx_err          <= 1'b0;
            src_mac         <= '0;
            src_ip          <= '0;
            src_port        <= '0;
            data_len        <= '0;
        end else begin
            cnt             <= (nxt != st) ? '0 : cnt + 16'd1;
            payload_valid_o <= 1'b0;
            payload_last_o  <= 1'b0;
            rx_done         <= 1'b0;
            rx_err          <= 1'b0;
            unique case (st)
                ETH_HDR: begin
                    if (gmii_rx_dv && cnt <= 16'd5) begin
                        uc_ok <= uc_now;
                        bc_ok <= bc_now;
                    end
                    if (gmii_rx_dv && cnt >= 16'd6 && cnt <= 16'd11) begin
                        sh_mac <= {sh_mac[39:0], gmii_rxd};
                    end
                end
                IP_HDR: begin
                    if (gmii_rx_dv && cnt >= 16'd12 && cnt <= 16'd15) begin
                        sh_ip <= {sh_ip[23:0], gmii_rxd};
                    end
                end
                UDP_HDR: begin
                    if (gmii_rx_dv && cnt <= 16'd1) begin
                        sh_port <= {sh_port[7:0], gmii_rxd};
                    end
                    if (gmii_rx_dv && (cnt == 16'd4 || cnt == 16'd5)) begin
                        sh_len <= len_now;
                    end
                    if (gmii_rx_dv && cnt == UDP_LAST) begin
                        src_mac  <= sh_mac;
                        src_ip   <= sh_ip;
                        src_port <= sh_port;
                        data_len <= sh_len - LEN_MIN;
                    end
                end
                PAYLOAD: begin
                    if (gmii_rx_dv) begin
                        payload_valid_o <= 1'b1;
                        payload_dat_o   <= gmii_rxd;
                        payload_last_o  <= cnt == data_len - 16'd1;
                    end else begin
                        rx_err <= 1'b1;
                    end
                end
                TRAILER: begin
                    if (!gmii_rx_dv) begin
                        rx_done <= crc_ok;
                        rx_err  <= !crc_ok;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_eth_udp_rx_gmii.sv
// Directed frame table for eth_udp_rx_gmii plus reset corner case.
// Expectations adapt when UDP_RX_CRC_CHECK_EN is defined.
module tb_eth_udp_rx_gmii;

    localparam logic [47:0] MY_MAC  = 48'h00_07_ed_ac_62_22;
    localparam logic [31:0] MY_IP   = 32'hc0_a8_00_03;
    localparam logic [15:0] MY_PORT = 16'd6102;
    localparam logic [47:0] SRC_MAC = 48'ha0_b1_c2_d3_e4_f5;
    localparam logic [31:0] SRC_IP  = 32'hc0_a8_00_02;
    localparam logic [15:0] SRC_PRT = 16'd5000;
    localparam logic [47:0] BCAST   = 48'hff_ff_ff_ff_ff_ff;

    logic        clk_125m = 1'b0;
    logic        udp_gmii_rst_n;
    logic        gmii_rx_dv;
    logic [7:0]  gmii_rxd;
    logic [47:0] local_mac;
    logic [31:0] local_ip;
    logic [15:0] local_port;
    logic        payload_valid_o;
    logic [7:0]  payload_dat_o;
    logic        payload_last_o;
    logic        rx_done;
    logic        rx_err;
    logic [47:0] src_mac;
    logic [31:0] src_ip;
    logic [15:0] src_port;
    logic [15:0] data_len;

    eth_udp_rx_gmii dut (
        .clk_125m        (clk_125m),
        .udp_gmii_rst_n  (udp_gmii_rst_n),
        .gmii_rx_dv      (gmii_rx_dv),
        .gmii_rxd        (gmii_rxd),
        .local_mac       (local_mac),
        .local_ip        (local_ip),
        .local_port      (local_port),
        .payload_valid_o (payload_valid_o),
        .payload_dat_o   (payload_dat_o),
        .payload_last_o  (payload_last_o),
        .rx_done         (rx_done),
        .rx_err          (rx_err),
        .src_mac         (src_mac),
        .src_ip          (src_ip),
        .src_port        (src_port),
        .data_len        (data_len)
    );

    always #4 clk_125m = ~clk_125m;

    typedef struct {
        string       name;
        logic [47:0] dmac;
        logic [15:0] etype;
        logic [31:0] dip;
        logic [15:0] dport;
        logic [15:0] ulen;
        int          npay;
        int          cut;
        bit          flip;
        int          e_nvalid;
        bit          e_last;
        bit          e_done;
        bit          e_err;
        bit          e_commit;
        logic [15:0] e_len;
    } vec_t;

    string msg = "Hello, welcome to FPGA!thanks";

    int n_run  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int fall   = 0;

    // Monitor state, written only by the monitor process.
    int         n_valid   = 0;
    int         n_last    = 0;
    int         n_done    = 0;
    int         n_err     = 0;
    int         pulse_cyc = -1;
    logic [7:0] last_dat  = 8'h00;
    logic [7:0] got[$];

    logic [7:0]  frm[$];
    logic [15:0] cur_len = 16'd0;
    bit          meta_set = 1'b0;
    vec_t        vt[13];

    always @(posedge clk_125m) cyc <= cyc + 1;

    always @(negedge clk_125m) begin
        if (payload_valid_o) begin
            got.push_back(payload_dat_o);
            n_valid = n_valid + 1;
            if (payload_last_o) begin
                n_last   = n_last + 1;
                last_dat = payload_dat_o;
            end
        end
        if (rx_done) n_done = n_done + 1;
        if (rx_err)  n_err  = n_err + 1;
        if (rx_done || rx_err) pulse_cyc = cyc;
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_run = n_run + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input string nm, input logic [47:0] dmac,
        input logic [15:0] etype, input logic [31:0] dip,
        input logic [15:0] dport, input logic [15:0] ulen,
        input int npay, input int cut, input bit flip,
        input int e_nvalid, input bit e_last, input bit e_done,
        input bit e_err, input bit e_commit, input logic [15:0] e_len);
        vec_t v;
        v.name = nm;      v.dmac = dmac;   v.etype = etype;
        v.dip = dip;      v.dport = dport; v.ulen = ulen;
        v.npay = npay;    v.cut = cut;     v.flip = flip;
        v.e_nvalid = e_nvalid; v.e_last = e_last;
        v.e_done = e_done;     v.e_err = e_err;
        v.e_commit = e_commit; v.e_len = e_len;
        return v;
    endfunction

    function automatic logic [31:0] fcs_of(input logic [7:0] q[$]);
        logic [31:0] c = 32'hffff_ffff;
        foreach (q[i]) begin
            c = c ^ {24'd0, q[i]};
            for (int k = 0; k < 8; k++) begin
                c = c[0] ? ((c >> 1) ^ 32'hedb8_8320) : (c >> 1);
            end
        end
        return ~c;
    endfunction

    task automatic put16(inout logic [7:0] q[$], input logic [15:0] v);
        q.push_back(v[15:8]);
        q.push_back(v[7:0]);
    endtask

    task automatic put32(inout logic [7:0] q[$], input logic [31:0] v);
        put16(q, v[31:16]);
        put16(q, v[15:0]);
    endtask

    task automatic build(input vec_t v);
        logic [7:0]  b[$];
        logic [31:0] f;
        put32(b, v.dmac[47:16]);
        put16(b, v.dmac[15:0]);
        put32(b, SRC_MAC[47:16]);
        put16(b, SRC_MAC[15:0]);
        put16(b, v.etype);
        put16(b, 16'h4500);
        put16(b, v.ulen + 16'd20);
        put32(b, 32'h0000_4000);
        put32(b, 32'h4011_0000);
        put32(b, SRC_IP);
        put32(b, v.dip);
        put16(b, SRC_PRT);
        put16(b, v.dport);
        put16(b, v.ulen);
        put16(b, 16'h0000);
        for (int i = 0; i < v.npay; i++) b.push_back(msg[i]);
        if (v.cut >= 0) begin
            while (b.size() > 42 + v.cut) void'(b.pop_back());
        end else begin
            while (b.size() < 60) b.push_back(8'h00);
            f = fcs_of(b);
            if (v.flip) f[0] = ~f[0];
            b.push_back(f[7:0]);
            b.push_back(f[15:8]);
            b.push_back(f[23:16]);
            b.push_back(f[31:24]);
        end
        frm.delete();
        for (int i = 0; i < 7; i++) frm.push_back(8'h55);
        frm.push_back(8'hd5);
        foreach (b[i]) frm.push_back(b[i]);
    endtask

    task automatic send();
        foreach (frm[i]) begin
            @(negedge clk_125m);
            gmii_rx_dv = 1'b1;
            gmii_rxd   = frm[i];
        end
        @(negedge clk_125m);
        gmii_rx_dv = 1'b0;
        gmii_rxd   = 8'h00;
        fall       = cyc;
        repeat (8) @(negedge clk_125m);
    endtask

    task automatic run_vec(input vec_t v);
        int b_valid = n_valid;
        int b_last  = n_last;
        int b_done  = n_done;
        int b_err   = n_err;
        int b_got   = got.size();
        int bad     = 0;
        build(v);
        send();
        for (int i = 0; i < n_valid - b_valid && i < v.npay; i++) begin
            if (got[b_got + i] !== msg[i]) bad++;
        end
        chk({v.name, "/nvalid"}, 64'(n_valid - b_valid), 64'(v.e_nvalid));
        chk({v.name, "/order"}, 64'(bad), 64'd0);
        chk({v.name, "/last"}, 64'(n_last - b_last), 64'(v.e_last));
        chk({v.name, "/done"}, 64'(n_done - b_done), 64'(v.e_done));
        chk({v.name, "/err"}, 64'(n_err - b_err), 64'(v.e_err));
        if (v.e_commit) begin
            cur_len  = v.e_len;
            meta_set = 1'b1;
        end
        chk({v.name, "/len"}, 64'(data_len), 64'(cur_len));
        if (v.e_last) begin
            chk({v.name, "/lastbyte"}, 64'(last_dat), 64'(8'h73));
        end
        if (v.e_done || v.e_err) begin
            chk({v.name, "/pulse_t"}, 64'(pulse_cyc), 64'(fall + 1));
        end
        if (meta_set) begin
            chk({v.name, "/src_ip"}, 64'(src_ip), 64'(SRC_IP));
            chk({v.name, "/src_port"}, 64'(src_port), 64'(SRC_PRT));
            chk({v.name, "/src_mac"}, 64'(src_mac), 64'(SRC_MAC));
        end
    endtask

    initial begin
        bit fl_done;
        bit fl_err;
        int b_valid;
        int b_done;
        int b_err;
`ifdef UDP_RX_CRC_CHECK_EN
        fl_done = 1'b0;
        fl_err  = 1'b1;
`else
        fl_done = 1'b1;
        fl_err  = 1'b0;
`endif
        vt[0]  = mk("good", MY_MAC, 16'h0800, MY_IP, MY_PORT, 16'd37,
                    29, -1, 0, 29, 1, 1, 0, 1, 16'd29);
        vt[1]  = mk("len8", MY_MAC, 16'h0800, MY_IP, MY_PORT, 16'd8,
                    0, -1, 0, 0, 0, 1, 0, 1, 16'd0);
        vt[2]  = mk("port6103", MY_MAC, 16'h0800, MY_IP, 16'd6103,
                    16'd37, 29, -1, 0, 0, 0, 0, 0, 0, 16'd0);
        vt[3]  = mk("arp", MY_MAC, 16'h0806, MY_IP, MY_PORT, 16'd37,
                    29, -1, 0, 0, 0, 0, 0, 0, 16'd0);
        vt[4]  = mk("len5", MY_MAC, 16'h0800, MY_IP, MY_PORT, 16'd5,
                    29, -1, 0, 0, 0, 0, 0, 0, 16'd0);
        vt[5]  = mk("len1481", MY_MAC, 16'h0800, MY_IP, MY_PORT,
                    16'd1481, 29, -1, 0, 0, 0, 0, 0, 0, 16'd0);
        vt[6]  = mk("bad_ip", MY_MAC, 16'h0800, 32'hc0a80004, MY_PORT,
                    16'd37, 29, -1, 0, 0, 0, 0, 0, 0, 16'd0);
        vt[7]  = mk("bad_mac", 48'h0007edac6223, 16'h0800, MY_IP,
                    MY_PORT, 16'd37, 29, -1, 0, 0, 0, 0, 0, 0, 16'd0);
        vt[8]  = mk("mix_mac", 48'hffffffac6222, 16'h0800, MY_IP,
                    MY_PORT, 16'd37, 29, -1, 0, 0, 0, 0, 0, 0, 16'd0);
        vt[9]  = mk("bcast", BCAST, 16'h0800, MY_IP, MY_PORT, 16'd37,
                    29, -1, 0, 29, 1, 1, 0, 1, 16'd29);
        vt[10] = mk("trunc10", MY_MAC, 16'h0800, MY_IP, MY_PORT,
                    16'd37, 29, 10, 0, 10, 0, 0, 1, 1, 16'd29);
        vt[11] = mk("good2", MY_MAC, 16'h0800, MY_IP, MY_PORT, 16'd37,
                    29, -1, 0, 29, 1, 1, 0, 1, 16'd29);
        vt[12] = mk("fcs_flip", MY_MAC, 16'h0800, MY_IP, MY_PORT,
                    16'd37, 29, -1, 1, 29, 1, fl_done, fl_err, 1,
                    16'd29);

        udp_gmii_rst_n = 1'b0;
        gmii_rx_dv     = 1'b0;
        gmii_rxd       = 8'h00;
        local_mac      = MY_MAC;
        local_ip       = MY_IP;
        local_port     = MY_PORT;
        repeat (3) @(negedge clk_125m);
        chk("rst/strobes", 64'({payload_valid_o, payload_last_o,
                                rx_done, rx_err}), 64'd0);
        chk("rst/meta", 64'(data_len | src_port | payload_dat_o),
            64'd0);
        chk("rst/src", 64'(src_mac ^ {16'd0, src_ip}), 64'd0);
        udp_gmii_rst_n = 1'b1;
        repeat (2) @(negedge clk_125m);

        foreach (vt[i]) run_vec(vt[i]);

        // Reset pulse while payload is streaming.
        build(vt[0]);
        for (int i = 0; i < 65; i++) begin
            @(negedge clk_125m);
            gmii_rx_dv = 1'b1;
            gmii_rxd   = frm[i];
        end
        @(negedge clk_125m);
        chk("midrst/valid_before", 64'(payload_valid_o), 64'd1);
        udp_gmii_rst_n = 1'b0;
        gmii_rxd       = frm[65];
        #1;
        chk("midrst/strobes", 64'({payload_valid_o, payload_last_o,
                                   rx_done, rx_err}), 64'd0);
        chk("midrst/len", 64'(data_len), 64'd0);
        chk("midrst/src", 64'({src_ip, src_port}), 64'd0);
        chk("midrst/dat", 64'(payload_dat_o), 64'd0);
        @(negedge clk_125m);
        gmii_rxd = frm[66];
        @(negedge clk_125m);
        udp_gmii_rst_n = 1'b1;
        b_valid = n_valid;
        b_done  = n_done;
        b_err   = n_err;
        for (int i = 67; i < frm.size(); i++) begin
            gmii_rxd = frm[i];
            @(negedge clk_125m);
        end
        gmii_rx_dv = 1'b0;
        gmii_rxd   = 8'h00;
        repeat (8) @(negedge clk_125m);
        chk("midrst/tail_silent",
            64'((n_valid - b_valid) + (n_done - b_done) + (n_err - b_err)),
            64'd0);
        cur_len  = 16'd0;
        meta_set = 1'b0;
        chk("midrst/len_held", 64'(data_len), 64'(cur_len));
        run_vec(vt[11]);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/eth_udp_rx_gmii.md
# eth_udp_rx_gmii

GMII-side UDP/IPv4 receiver for the 125 MHz Ethernet path. Consumes the byte stream from the RGMII-to-GMII converter, strips preamble/SFD, Ethernet, IPv4 and UDP headers, filters on local MAC/IP/port and streams the UDP payload out byte-by-byte with frame metadata. It is the receive counterpart of `eth_udp_tx_gmii` and sits between the PHY interface and user logic.

## Interface
- MAX_PAYLOAD, 1472, largest accepted UDP payload in bytes; a larger UDP length drops the frame.
- clk_125m  in  1  GMII receive clock, 125 MHz.
- udp_gmii_rst_n  in  1  asynchronous, active-low reset; all state and outputs cleared.
- gmii_rx_dv  in  1  GMII receive data valid.
- gmii_rxd  in  8  GMII receive byte.
- local_mac  in  48  station MAC; broadcast ff_ff_ff_ff_ff_ff is also accepted.
- local_ip  in  32  station IPv4 address.
- local_port  in  16  listening UDP port.
- payload_valid_o  out  1  payload byte strobe.
- payload_dat_o  out  8  payload byte.
- payload_last_o  out  1  high with the final payload byte.
- rx_done  out  1  one-cycle pulse: frame accepted and complete.
- rx_err  out  1  one-cycle pulse: accepted frame truncated or bad (CRC when enabled).
- src_mac / src_ip / src_port  out  48/32/16  sender fields of the last accepted frame.
- data_len  out  16  payload length of the last accepted frame (UDP length − 8).

## Operation
- States: IDLE, PREAMBLE, ETH_HDR, IP_HDR, UDP_HDR, PAYLOAD, TRAILER, DROP.
- IDLE: on gmii_rx_dv=1 with byte 0x55 -> PREAMBLE; any other byte -> DROP.
- PREAMBLE: 0x55 stays; 0xD5 -> ETH_HDR; anything else -> DROP. Each header state uses a byte counter that is reset on state entry.
- ETH_HDR, 14 bytes: dst MAC must equal local_mac or broadcast; EtherType must be 0x0800; src MAC is captured into a shadow register.
- IP_HDR, 20 bytes: byte0 must be 0x45 (options are not supported); protocol must be 17; dst IP must equal local_ip; src IP is shadowed. The IP checksum is not verified.
- UDP_HDR, 8 bytes: dst port must equal local_port. UDP length L is required to satisfy 8 ≤ L ≤ MAX_PAYLOAD+8. After the last header byte, src_mac, src_ip, src_port and data_len = L−8 are committed from the shadow registers together.
- PAYLOAD: forwards data_len bytes. When data_len=0, go directly to TRAILER.
- TRAILER: discards padding and FCS until gmii_rx_dv=0, then pulses rx_done and returns to IDLE.
- DROP: any filter or format mismatch. No outputs, no pulses; wait for gmii_rx_dv=0, then IDLE. Filtered frames are silent.
- gmii_rx_dv falling in ETH_HDR, IP_HDR or UDP_HDR: silent return to IDLE.
- gmii_rx_dv falling in PAYLOAD before the last byte: pulse rx_err with no payload_last_o, then IDLE.
- Metadata outputs hold their value until the next commit.
- Arithmetic: all length math is 16-bit unsigned. The L<8 check is done before subtraction, so there is no wrap.

## Timing
- Reset values: every output is 0, and the state is IDLE.
- Payload latency: payload_dat_o and payload_valid_o are registered, 1 cycle after the corresponding gmii_rxd byte. Valid is contiguous; there is no backpressure, and the sink must accept every byte.
- rx_done / rx_err assert exactly 1 cycle after the cycle where gmii_rx_dv is first sampled 0.
- A new frame can start on the cycle after gmii_rx_dv=0 is sampled. The IPG is not checked.
- Reset asserted mid-frame: outputs clear immediately, no pulse is emitted, and after release the FSM waits in IDLE. Bytes from the partial frame that arrive after release are dropped via DROP because they do not start with 0x55.

## Configuration
- UDP_RX_CRC_CHECK_EN defined:
  - CRC-32 is computed over every byte from the destination MAC through the FCS.
  - At end of frame, a residue of 0xC704DD7B gives rx_done; any other residue gives rx_err instead.
  - Payload has already been streamed, so sinks must qualify the data with rx_done.
- Undefined: no CRC logic is built, the FCS is ignored, and rx_done is issued for every complete accepted frame.

## Structure
- Package eth_udp_pkg holds:
  - the state enum;
  - PREAMBLE_BYTE 0x55 and SFD_BYTE 0xD5;
  - ETH_TYPE_IPV4 0x0800 and IP_PROTO_UDP 17;
  - header lengths 14/20/8;
  - CRC_RESIDUE 0xC704DD7B.
- One sub-module, crc32_d8: byte-wide, reflected CRC-32 (polynomial 0x04C11DB7, init 0xFFFFFFFF). It is instantiated only under UDP_RX_CRC_CHECK_EN.

## Test plan
- Frame to local_mac 00_07_ed_ac_62_22, IP c0_a8_00_03, port 6102, from 192.168.0.2:5000, with 29-byte payload "Hello, welcome to FPGA!thanks":
  - payload bytes appear in order, with last on 's';
  - data_len=29, src_ip=c0_a8_00_02, src_port=5000;
  - rx_done is 1 cycle after dv falls.
- Same frame with dst MAC ff_ff_ff_ff_ff_ff -> accepted. With dst port 6103 or EtherType 0x0806 -> no payload_valid, no rx_done, no rx_err.
- dv dropped after payload byte 10 -> 10 valid bytes, no last, rx_err pulse, and the next good frame is received correctly.
- UDP length 8 -> no payload, data_len=0, rx_done. UDP length 5 -> dropped silently.
- With UDP_RX_CRC_CHECK_EN: good FCS -> rx_done. One FCS bit flipped -> rx_err, not rx_done.
- Reset pulse during PAYLOAD -> outputs 0 at once; the following complete frame is received correctly.
